// File: rtl/pyrite_bpi_apb_read_seq.sv
// APB requester that reads words from the Pyrite BPI flash-control block.
// Each command: CTRL setup write, then per word an ADDR write, a one-time OE
// write, a tACC wait and a DATA read; words stream out on a valid/ready port.
// A final CTRL write releases the bus. A slave error aborts to the release.

module pyrite_bpi_apb_read_seq #(
    parameter int unsigned FLASH_DATA_W = 16,
    parameter int unsigned FLASH_ADDR_W = 23,
    parameter int unsigned FLASH_RGN_W  = 1,
    parameter logic [15:0] BASE_ADDR    = 16'h0040,
    parameter int unsigned WAIT_CYCLES  = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [FLASH_ADDR_W+FLASH_RGN_W-1:0] cmd_addr,
    input  logic [CNT_W-1:0]                    cmd_len,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    output logic [FLASH_DATA_W-1:0]             rd_data,
    output logic                                rd_last,
    output logic                                rd_valid,
    input  logic                                rd_ready,
    output logic                                busy,
    output logic                                done,
    output logic                                done_err,
    output logic [15:0]                         m_apb_paddr,
    output logic                                m_apb_psel,
    output logic                                m_apb_penable,
    output logic                                m_apb_pwrite,
    output logic [31:0]                         m_apb_pwdata,
    output logic [3:0]                          m_apb_pstrb,
    input  logic [31:0]                         m_apb_prdata,
    input  logic                                m_apb_pready,
    input  logic                                m_apb_pslverr
);

    localparam int unsigned FA = FLASH_ADDR_W + FLASH_RGN_W;
    localparam int unsigned WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WW-1:0] WaitLoad = WW'(WAIT_CYCLES - 1);

    localparam logic [15:0] CtrlAddr = BASE_ADDR + 16'h0010;
    localparam logic [15:0] AddrAddr = BASE_ADDR + 16'h0014;
    localparam logic [15:0] DataAddr = BASE_ADDR + 16'h0018;

    // ce_n=0, oe_n=1, we_n=1, adv_n=0, region_oe=1
    localparam logic [31:0] CtrlSetup   = 32'h0001_0006;
    // same as setup with oe_n driven low
    localparam logic [31:0] CtrlOe      = 32'h0001_0004;
    // all strobes deasserted, outputs released
    localparam logic [31:0] CtrlRelease = 32'h0000_000F;

    localparam logic [3:0] StIdle    = 4'd0;
    localparam logic [3:0] StNull    = 4'd1;  // zero-length command, done pulse cycle
    localparam logic [3:0] StSetup   = 4'd2;
    localparam logic [3:0] StAddr    = 4'd3;
    localparam logic [3:0] StOe      = 4'd4;
    localparam logic [3:0] StWait    = 4'd5;
    localparam logic [3:0] StData    = 4'd6;
    localparam logic [3:0] StOut     = 4'd7;
    localparam logic [3:0] StRelease = 4'd8;

    // APB sub-phase inside a transfer state; Gap forces the mandatory idle
    // cycle when one transfer directly follows another.
    localparam logic [1:0] PhGap    = 2'd0;
    localparam logic [1:0] PhSetup  = 2'd1;
    localparam logic [1:0] PhAccess = 2'd2;

    logic [3:0]              state_q, state_d;
    logic [1:0]              ph_q, ph_d;
    logic [FA-1:0]           addr_q, addr_d;
    logic [CNT_W-1:0]        rem_q, rem_d;
    logic [WW-1:0]           wait_q, wait_d;
    logic [FLASH_DATA_W-1:0] data_q, data_d;
    logic                    first_q, first_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic                    done_err_q, done_err_d;
    logic                    is_xfer;

    // Decode which states own an APB transfer
    always_comb begin
        is_xfer = 1'b0;
        case (state_q)
            StSetup, StAddr, StOe, StData, StRelease: is_xfer = 1'b1;
            default: is_xfer = 1'b0;
        endcase
    end

    // Status and stream outputs
    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        rd_valid  = (state_q == StOut);
        rd_last   = (state_q == StOut) && (rem_q == CNT_W'(1));
        rd_data   = data_q;
        done      = done_q;
        done_err  = done_err_q;
    end

    // APB request lines; address/data held constant from setup to completion
    always_comb begin
        m_apb_psel    = is_xfer && (ph_q != PhGap);
        m_apb_penable = is_xfer && (ph_q == PhAccess);
        m_apb_paddr   = '0;
        m_apb_pwrite  = 1'b0;
        m_apb_pwdata  = '0;
        m_apb_pstrb   = '0;
        if (m_apb_psel) begin
            case (state_q)
                StSetup: begin
                    m_apb_paddr  = CtrlAddr;
                    m_apb_pwrite = 1'b1;
                    m_apb_pwdata = CtrlSetup;
                    m_apb_pstrb  = 4'b0111;
                end
                StAddr: begin
                    m_apb_paddr  = AddrAddr;
                    m_apb_pwrite = 1'b1;
                    m_apb_pwdata = 32'(addr_q);
                    m_apb_pstrb  = 4'b1111;
                end
                StOe: begin
                    m_apb_paddr  = CtrlAddr;
                    m_apb_pwrite = 1'b1;
                    m_apb_pwdata = CtrlOe;
                    m_apb_pstrb  = 4'b0111;
                end
                StData: begin
                    m_apb_paddr  = DataAddr;
                end
                StRelease: begin
                    m_apb_paddr  = CtrlAddr;
                    m_apb_pwrite = 1'b1;
                    m_apb_pwdata = CtrlRelease;
                    m_apb_pstrb  = 4'b0111;
                end
                default: ;
            endcase
        end
    end

    // Sequencer next-state
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        wait_d     = wait_q;
        data_d     = data_q;
        first_d    = first_q;
        err_d      = err_q;
        done_d     = 1'b0;
        done_err_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    first_d = 1'b1;
                    err_d   = 1'b0;
                    if (cmd_len == '0) begin
                        state_d = StNull;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StSetup;
                        ph_d    = PhSetup;
                    end
                end
            end

            StNull: state_d = StIdle;

            StWait: begin
                if (wait_q == '0) begin
                    state_d = StData;
                    ph_d    = PhSetup;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end

            StOut: begin
                // nothing moves on the bus while the consumer stalls
                if (rd_ready) begin
                    rem_d  = rem_q - CNT_W'(1);
                    addr_d = addr_q + FA'(1);
                    ph_d   = PhSetup;
                    state_d = (rem_q == CNT_W'(1)) ? StRelease : StAddr;
                end
            end

            StSetup, StAddr, StOe, StData, StRelease: begin
                if (ph_q == PhGap) begin
                    ph_d = PhSetup;
                end else if (ph_q == PhSetup) begin
                    ph_d = PhAccess;
                end else if (m_apb_pready) begin
                    ph_d = PhGap;
                    if (m_apb_pslverr && (state_q != StRelease)) begin
                        err_d   = 1'b1;
                        state_d = StRelease;
                    end else begin
                        case (state_q)
                            StSetup: state_d = StAddr;
                            StAddr: begin
                                if (first_q) begin
                                    state_d = StOe;
                                end else begin
                                    state_d = StWait;
                                    wait_d  = WaitLoad;
                                end
                            end
                            StOe: begin
                                first_d = 1'b0;
                                state_d = StWait;
                                wait_d  = WaitLoad;
                            end
                            StData: begin
                                data_d  = m_apb_prdata[FLASH_DATA_W-1:0];
                                state_d = StOut;
                            end
                            default: begin
                                state_d    = StIdle;
                                done_d     = 1'b1;
                                done_err_d = err_q;
                            end
                        endcase
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ph_q       <= PhGap;
            addr_q     <= '0;
            rem_q      <= '0;
            wait_q     <= '0;
            data_q     <= '0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            wait_q     <= wait_d;
            data_q     <= data_d;
            first_q    <= first_d;
            err_q      <= err_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
        end
    end

endmodule

// File: tb/tb_pyrite_bpi_apb_read_seq.sv
// Bench for pyrite_bpi_apb_read_seq: a registered-pready APB responder that
// models the BPI block over a fixed flash image, a bus/stream monitor, and a
// transaction-level model of the expected APB sequence and output words.

module tb_pyrite_bpi_apb_read_seq;

    localparam logic [15:0] A_CTRL = 16'h0050;
    localparam logic [15:0] A_ADDR = 16'h0054;
    localparam logic [15:0] A_DATA = 16'h0058;
    localparam int WAIT_CYCLES = 8;

    logic        clk;
    logic        rst;
    logic [23:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] rd_data;
    logic        rd_last;
    logic        rd_valid;
    logic        rd_ready;
    logic        busy;
    logic        done;
    logic        done_err;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    pyrite_bpi_apb_read_seq dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .rd_data       (rd_data),
        .rd_last       (rd_last),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .busy          (busy),
        .done          (done),
        .done_err      (done_err),
        .m_apb_paddr   (paddr),
        .m_apb_psel    (psel),
        .m_apb_penable (penable),
        .m_apb_pwrite  (pwrite),
        .m_apb_pwdata  (pwdata),
        .m_apb_pstrb   (pstrb),
        .m_apb_prdata  (prdata),
        .m_apb_pready  (pready),
        .m_apb_pslverr (pslverr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // monitor outputs
    logic [52:0] apb_q[$];
    logic [16:0] word_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          acc_cyc = 0;
    int          last_cmp_cyc = 0;
    logic        done_err_s = 1'b0;
    logic        done_rdy_s = 1'b0;
    int          dgap_min = 1000;
    int          err_at = -1;
    logic [23:0] addr_reg;

    typedef struct {
        logic [23:0] addr;
        int          len;
        int          err_at;
        int          stall_w;
        int          stall_n;
        int          exp_nx;
        int          exp_nw;
    } vec_t;

    vec_t vecs[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // flash image seen through the DATA register
    function automatic logic [15:0] mem(input logic [23:0] a);
        return a[15:0] ^ 16'hBFCC ^ {a[23:16], 8'h00};
    endfunction

    function automatic logic [52:0] rec(input logic [15:0] a, input logic w,
                                        input logic [31:0] d, input logic [3:0] s);
        return {a, w, d, s};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        check(name, 64'(got), 64'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Responder: pready registered one cycle into the access phase
    initial begin
        pready   = 1'b0;
        pslverr  = 1'b0;
        prdata   = '0;
        addr_reg = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                pready  <= 1'b0;
                pslverr <= 1'b0;
                prdata  <= '0;
            end else if (psel && penable && !pready) begin
                pready  <= 1'b1;
                pslverr <= (err_at >= 0) && (apb_q.size() == err_at);
                prdata  <= {16'hDEAD, mem(addr_reg)};
            end else begin
                pready  <= 1'b0;
                pslverr <= 1'b0;
            end
            if (!rst && psel && penable && pready && pwrite && paddr == A_ADDR)
                addr_reg <= pwdata[23:0];
        end
    end

    // Monitor: logs completed transfers and words, checks bus/stream rules
    initial begin
        int          idle_run;
        logic [52:0] setup_rec;
        logic [52:0] cur;
        logic        prev_stall;
        logic [15:0] prev_data;
        logic        prev_last;
        idle_run   = 1;
        setup_rec  = '0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                idle_run   = 1;
            end else begin
                cur = {paddr, pwrite, pwdata, pstrb};
                if (cmd_valid && cmd_ready) acc_cyc = cyc;
                if (done) begin
                    done_cnt++;
                    done_cyc   = cyc;
                    done_err_s = done_err;
                    done_rdy_s = cmd_ready;
                end
                if (psel) begin
                    if (!penable) begin
                        check_bit("apb_idle_before_setup", idle_run != 0, 1'b1);
                        if (paddr == A_DATA && idle_run < dgap_min) dgap_min = idle_run;
                        setup_rec = cur;
                    end else if (pready) begin
                        check("apb_stable", 64'(cur), 64'(setup_rec));
                        apb_q.push_back(pwrite ? cur : {paddr, 1'b0, 36'h0});
                        last_cmp_cyc = cyc;
                    end
                    idle_run = 0;
                end else begin
                    idle_run++;
                end
                if (prev_stall)
                    check("rd_hold", 64'({rd_valid, rd_last, rd_data, psel}),
                          64'({1'b1, prev_last, prev_data, 1'b0}));
                if (rd_valid && rd_ready) word_q.push_back({rd_last, rd_data});
                prev_stall = rd_valid && !rd_ready;
                prev_data  = rd_data;
                prev_last  = rd_last;
            end
        end
    end

    // One command against the transaction-level model
    task automatic run_cmd(input logic [23:0] a, input int len, input int err_i,
                           input int stall_w, input int stall_n, input bit rnd,
                           input int exp_nx, input int exp_nw);
        logic [52:0] full[$];
        int          word_of[$];
        logic [52:0] exp_x[$];
        logic [16:0] exp_w[$];
        logic        exp_err;
        bit          has_read;
        int          n;
        int          d0;
        int          budget;
        int          stall_ctr;

        // model: full sequence, truncated at the faulting transfer
        exp_err  = 1'b0;
        has_read = 1'b0;
        if (len > 0) begin
            full.push_back(rec(A_CTRL, 1'b1, 32'h0001_0006, 4'h7));
            word_of.push_back(-1);
            for (int i = 0; i < len; i++) begin
                full.push_back(rec(A_ADDR, 1'b1, {8'h00, a + 24'(i)}, 4'hF));
                word_of.push_back(-1);
                if (i == 0) begin
                    full.push_back(rec(A_CTRL, 1'b1, 32'h0001_0004, 4'h7));
                    word_of.push_back(-1);
                end
                full.push_back(rec(A_DATA, 1'b0, 32'h0, 4'h0));
                word_of.push_back(i);
            end
            n = full.size();
            if (err_i >= 0 && err_i < n) begin
                n = err_i + 1;
                exp_err = 1'b1;
            end
            for (int k = 0; k < n; k++) begin
                exp_x.push_back(full[k]);
                if (word_of[k] >= 0) has_read = 1'b1;
                if (word_of[k] >= 0 && !(exp_err && k == n - 1))
                    exp_w.push_back({word_of[k] == len - 1, mem(a + 24'(word_of[k]))});
            end
            exp_x.push_back(rec(A_CTRL, 1'b1, 32'h0000_000F, 4'h7));
        end

        step();
        apb_q.delete();
        word_q.delete();
        dgap_min  = 1000;
        err_at    = err_i;
        d0        = done_cnt;
        stall_ctr = 0;
        cmd_addr  = a;
        cmd_len   = 16'(len);
        cmd_valid = 1'b1;
        rd_ready  = 1'b1;
        check_bit("cmd_ready_idle", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        budget = 3000;
        while (done_cnt == d0 && budget > 0) begin
            if (stall_w >= 0 && word_q.size() == stall_w && rd_valid && stall_ctr < stall_n) begin
                rd_ready = 1'b0;
                stall_ctr++;
            end else if (rnd) begin
                rd_ready = ($urandom_range(0, 3) != 0);
            end else begin
                rd_ready = 1'b1;
            end
            step();
            budget--;
        end
        rd_ready = 1'b1;
        check("done_seen", 64'(done_cnt - d0), 64'd1);
        check_bit("idle_after_done", busy, 1'b0);

        check("apb_count", 64'(apb_q.size()), 64'(exp_x.size()));
        for (int k = 0; k < exp_x.size() && k < apb_q.size(); k++)
            check("apb_xfer", 64'(apb_q[k]), 64'(exp_x[k]));
        check("word_count", 64'(word_q.size()), 64'(exp_w.size()));
        for (int k = 0; k < exp_w.size() && k < word_q.size(); k++)
            check("word", 64'(word_q[k]), 64'(exp_w[k]));
        check_bit("done_err", done_err_s, exp_err);
        if (exp_nx >= 0) check("apb_count_tab", 64'(apb_q.size()), 64'(exp_nx));
        if (exp_nw >= 0) check("word_count_tab", 64'(word_q.size()), 64'(exp_nw));
        if (len == 0) begin
            check("zero_len_latency", 64'(done_cyc - acc_cyc), 64'd1);
            check_bit("zero_len_ready", done_rdy_s, 1'b0);
        end else begin
            check("done_after_release", 64'(done_cyc - last_cmp_cyc), 64'd1);
            check_bit("done_with_ready", done_rdy_s, 1'b1);
        end
        if (has_read) check_bit("data_wait_gap", dgap_min >= WAIT_CYCLES, 1'b1);
        step();
        step();
        check("done_one_pulse", 64'(done_cnt - d0), 64'd1);
        err_at = -1;
    endtask

    initial begin
        int budget;
        logic [23:0] ra;
        int rl;
        int re;

        vecs[0] = '{24'h000123, 1, -1, -1, 0, 5, 1};
        vecs[1] = '{24'hFFFFFE, 4, -1, -1, 0, 11, 4};
        vecs[2] = '{24'h0ABCDE, 2, -1, 0, 10, 7, 2};
        vecs[3] = '{24'h000400, 3, 1, -1, 0, 3, 0};
        vecs[4] = '{24'h000777, 0, -1, -1, 0, 0, 0};
        vecs[5] = '{24'h800010, 2, 5, -1, 0, 7, 1};
        vecs[6] = '{24'h000010, 1, 4, -1, 0, 5, 1};

        rst       = 1'b1;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_valid = 1'b0;
        rd_ready  = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_ctl", 64'({cmd_ready, rd_valid, rd_last, rd_data, busy, done, done_err}),
              64'({1'b1, 21'h0}));
        check("reset_apb", 64'({psel, penable, pwrite, paddr, pwdata, pstrb}), 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_cmd(vecs[i].addr, vecs[i].len, vecs[i].err_at, vecs[i].stall_w,
                    vecs[i].stall_n, 1'b0, vecs[i].exp_nx, vecs[i].exp_nw);
            if (i == 0 && word_q.size() > 0)
                check("first_word_beef", 64'(word_q[0]), 64'({1'b1, 16'hBEEF}));
        end

        // reset while waiting on tACC
        step();
        apb_q.delete();
        word_q.delete();
        err_at    = -1;
        rd_ready  = 1'b1;
        cmd_addr  = 24'h002222;
        cmd_len   = 16'd2;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        budget = 200;
        while (apb_q.size() < 3 && budget > 0) begin
            step();
            budget--;
        end
        check_bit("wait_reached", budget > 0, 1'b1);
        step();
        step();
        check_bit("busy_in_wait", busy, 1'b1);
        check_bit("psel_in_wait", psel, 1'b0);
        rst = 1'b1;
        step();
        @(negedge clk);
        check("reset_midop", 64'({psel, busy, rd_valid}), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check_bit("ready_after_rst", cmd_ready, 1'b1);
        run_cmd(24'h000456, 1, -1, -1, 0, 1'b0, 5, 1);

        // randomized commands, random backpressure and fault placement
        for (int i = 0; i < 16; i++) begin
            ra = 24'($urandom);
            rl = int'($urandom_range(0, 5));
            re = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * rl + 2)) : -1;
            run_cmd(ra, rl, re, -1, 0, 1'b1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1);
    end

endmodule
